// File: rtl/game_sequencer.sv
// Game flow controller: IDLE -> INIT -> PLAY <-> LEVEL_UP -> WON/LOST, with a
// play-speed tick divider, hit score counter and synchronized board inputs.
module game_sequencer #(
  parameter int TICK_DIV    = 2097152,
  parameter int INIT_CYCLES = 4,
  parameter int MAX_LEVEL   = 4
) (
  input  logic       board_clk,
  input  logic       reset,
  input  logic       start,
  input  logic       aliens_defeated,
  input  logic       reached_bottom,
  input  logic       collision,
  output logic       game_rst,
  output logic       tick_en,
  output logic [2:0] state,
  output logic [1:0] level,
  output logic [7:0] score,
  output logic       win,
  output logic       lose
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    INIT     = 3'd1,
    PLAY     = 3'd2,
    LEVEL_UP = 3'd3,
    WON      = 3'd4,
    LOST     = 3'd5
  } state_t;

  localparam logic [7:0]  PHASE_LAST = 8'(INIT_CYCLES - 1);
  localparam logic [23:0] DIV_LAST   = 24'(TICK_DIV - 1);
  localparam logic [23:0] DIV_PRE    = 24'(TICK_DIV - 2);
  localparam logic [1:0]  LEVEL_TOP  = 2'(MAX_LEVEL - 1);

  function automatic logic [7:0] sat_inc(input logic [7:0] val);
    return (val == 8'hFF) ? val : val + 8'd1;
  endfunction

  state_t      cur, nxt;
  logic [3:0]  raw, sync_p0, sync_p1;
  logic        start_p2, coll_p2;
  logic [1:0]  fill_cnt;
  logic        start_armed;
  logic [7:0]  phase_cnt;
  logic [23:0] div_cnt;

  logic start_s, aliens_s, bottom_s, coll_s;
  logic start_rise, coll_rise;
  logic rst_nxt, tick_nxt;

  assign raw      = {collision, reached_bottom, aliens_defeated, start};
  assign start_s  = sync_p1[0];
  assign aliens_s = sync_p1[1];
  assign bottom_s = sync_p1[2];
  assign coll_s   = sync_p1[3];

  // A start level that was already high when reset released is not an edge:
  // the rise only counts once start has been genuinely seen low.
  assign start_rise = start_s & ~start_p2 & start_armed;
  assign coll_rise  = coll_s & ~coll_p2;

  assign state = cur;

  always_comb begin
    nxt      = cur;
    rst_nxt  = 1'b0;
    tick_nxt = 1'b0;
    case (cur)
      IDLE: begin
        if (start_rise) nxt = INIT;
      end
      INIT, LEVEL_UP: begin
        if (phase_cnt == PHASE_LAST) nxt = PLAY;
      end
      PLAY: begin
        if (!start_s)       nxt = IDLE;
        else if (bottom_s)  nxt = LOST;
        else if (aliens_s)  nxt = (level == LEVEL_TOP) ? WON : LEVEL_UP;
      end
      WON, LOST: begin
        if (!start_s) nxt = IDLE;
      end
      default: nxt = IDLE;
    endcase
    rst_nxt  = (nxt == IDLE) || (nxt == INIT) || (nxt == LEVEL_UP);
    tick_nxt = (cur == PLAY) && (nxt == PLAY) && (div_cnt == DIV_PRE);
  end

  always_ff @(posedge board_clk) begin
    if (reset) begin
      sync_p0     <= '0;
      sync_p1     <= '0;
      start_p2    <= 1'b0;
      coll_p2     <= 1'b0;
      fill_cnt    <= '0;
      start_armed <= 1'b0;
      cur         <= IDLE;
      phase_cnt   <= '0;
      div_cnt     <= '0;
      game_rst    <= 1'b1;
      tick_en     <= 1'b0;
      win         <= 1'b0;
      lose        <= 1'b0;
      score       <= '0;
      level       <= '0;
    end else begin
      // sync stage boundary: raw -> p0 -> p1, p2 holds previous p1 for edges
      sync_p0  <= raw;
      sync_p1  <= sync_p0;
      start_p2 <= start_s;
      coll_p2  <= coll_s;
      if (fill_cnt != 2'd2) fill_cnt <= fill_cnt + 2'd1;
      if ((fill_cnt == 2'd2) && !start_s) start_armed <= 1'b1;

      cur <= nxt;
      if (nxt != cur)
        phase_cnt <= '0;
      else if ((cur == INIT) || (cur == LEVEL_UP))
        phase_cnt <= phase_cnt + 8'd1;

      if (cur != PLAY || div_cnt == DIV_LAST)
        div_cnt <= '0;
      else
        div_cnt <= div_cnt + 24'd1;

      game_rst <= rst_nxt;
      tick_en  <= tick_nxt;
      win      <= (nxt == WON);
      lose     <= (nxt == LOST);

      if ((cur == IDLE) && start_rise)
        score <= '0;
      else if ((cur == PLAY) && coll_rise)
        score <= sat_inc(score);

      if ((cur == IDLE) && start_rise)
        level <= '0;
      else if ((cur == PLAY) && (nxt == LEVEL_UP))
        level <= level + 2'd1;
    end
  end

endmodule

// File: tb/tb_game_sequencer.sv
// Directed scenarios plus a randomized phase for game_sequencer, each cycle
// compared against a rule-level model of the game flow.
module tb_game_sequencer;

  localparam int TICK_DIV    = 8;
  localparam int INIT_CYCLES = 4;
  localparam int MAX_LEVEL   = 2;

  logic       board_clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       aliens_defeated = 1'b0;
  logic       reached_bottom = 1'b0;
  logic       collision = 1'b0;
  logic       game_rst, tick_en, win, lose;
  logic [2:0] state;
  logic [1:0] level;
  logic [7:0] score;

  int checks = 0;
  int errors = 0;

  game_sequencer #(
    .TICK_DIV(TICK_DIV),
    .INIT_CYCLES(INIT_CYCLES),
    .MAX_LEVEL(MAX_LEVEL)
  ) dut (
    .board_clk(board_clk),
    .reset(reset),
    .start(start),
    .aliens_defeated(aliens_defeated),
    .reached_bottom(reached_bottom),
    .collision(collision),
    .game_rst(game_rst),
    .tick_en(tick_en),
    .state(state),
    .level(level),
    .score(score),
    .win(win),
    .lose(lose)
  );

  always #5 board_clk = ~board_clk;

  // Reference model: state with time-in-state, inputs seen two edges late.
  int         m_state, m_time, m_level, m_score;
  logic [3:0] m_s1, m_s2;
  bit         m_start_prev, m_coll_prev, m_g1, m_g2, m_armed;

  always @(posedge board_clk) begin
    int nxt;
    bit st, ad, rb, co, st_rise, co_rise;
    if (reset) begin
      m_state = 0; m_time = 1; m_level = 0; m_score = 0;
      m_s1 = '0; m_s2 = '0; m_start_prev = 0; m_coll_prev = 0;
      m_g1 = 0; m_g2 = 0; m_armed = 0;
    end else begin
      st = m_s2[0]; ad = m_s2[1]; rb = m_s2[2]; co = m_s2[3];
      st_rise = st && !m_start_prev && m_armed;
      co_rise = co && !m_coll_prev;
      nxt = m_state;
      case (m_state)
        0: if (st_rise) begin nxt = 1; m_score = 0; m_level = 0; end
        1, 3: if (m_time == INIT_CYCLES) nxt = 2;
        2: begin
          if (co_rise && m_score < 255) m_score++;
          if (!st) nxt = 0;
          else if (rb) nxt = 5;
          else if (ad) begin
            if (m_level == MAX_LEVEL - 1) nxt = 4;
            else begin nxt = 3; m_level++; end
          end
        end
        default: if (!st) nxt = 0;
      endcase
      m_time = (nxt == m_state) ? m_time + 1 : 1;
      m_state = nxt;
      if (m_g2 && !st) m_armed = 1;
      m_start_prev = st; m_coll_prev = co;
      m_g2 = m_g1; m_g1 = 1;
      m_s2 = m_s1;
      m_s1 = {collision, reached_bottom, aliens_defeated, start};
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic compare_model();
    chk("m_state", state, m_state);
    chk("m_game_rst", game_rst, (m_state == 0 || m_state == 1 || m_state == 3));
    chk("m_tick_en", tick_en, (m_state == 2 && (m_time % TICK_DIV) == 0));
    chk("m_level", level, m_level);
    chk("m_score", score, m_score);
    chk("m_win", win, (m_state == 4));
    chk("m_lose", lose, (m_state == 5));
  endtask

  task automatic cycle();
    @(posedge board_clk);
    @(negedge board_clk);
    compare_model();
  endtask

  task automatic wait_state(input logic [2:0] tgt, input int limit, input string tag);
    int n = 0;
    while (state !== tgt && n < limit) begin
      cycle();
      n++;
    end
    chk(tag, state, tgt);
  endtask

  task automatic hits(input int count);
    for (int i = 0; i < count; i++) begin
      collision = 1'b1; cycle();
      collision = 1'b0; cycle();
    end
    repeat (3) cycle();
  endtask

  initial begin
    int n;
    logic [24:0] ticks, ticks_exp;

    // Reset state
    repeat (3) cycle();
    chk("rst_state", state, 0);
    chk("rst_game_rst", game_rst, 1);
    chk("rst_tick", tick_en, 0);
    chk("rst_score", score, 0);
    chk("rst_level", level, 0);
    chk("rst_win", win, 0);
    chk("rst_lose", lose, 0);
    reset = 1'b0;
    repeat (3) cycle();

    // Start edge: INIT on the third edge, INIT_CYCLES of game_rst, then PLAY
    start = 1'b1;
    cycle(); cycle();
    chk("init_not_yet", state, 0);
    cycle();
    chk("init_edge3", state, 1);
    n = 0;
    while (state == 3'd1 && n < 20) begin
      chk("init_game_rst", game_rst, 1);
      n++;
      cycle();
    end
    chk("init_len", n, INIT_CYCLES);
    chk("play_entry", state, 2);
    chk("play_game_rst", game_rst, 0);
    ticks = '0;
    ticks_exp = '0;
    for (int c = 1; c <= 24; c++) begin
      ticks[c] = tick_en;
      if (c % TICK_DIV == 0) ticks_exp[c] = 1'b1;
      if (c < 24) cycle();
    end
    chk("tick_pattern", ticks, ticks_exp);

    // Two waves: LEVEL_UP then WON
    aliens_defeated = 1'b1;
    wait_state(3'd3, 10, "levelup");
    aliens_defeated = 1'b0;
    chk("levelup_level", level, 1);
    n = 0;
    while (state == 3'd3 && n < 20) begin
      chk("levelup_game_rst", game_rst, 1);
      n++;
      cycle();
    end
    chk("levelup_len", n, INIT_CYCLES);
    chk("levelup_back", state, 2);
    repeat (4) cycle();
    aliens_defeated = 1'b1;
    wait_state(3'd4, 10, "won");
    aliens_defeated = 1'b0;
    chk("won_win", win, 1);
    chk("won_tick", tick_en, 0);
    chk("won_level", level, 1);
    start = 1'b0;
    wait_state(3'd0, 10, "won_to_idle");

    // Simultaneous bottom and defeated: LOST wins
    start = 1'b1;
    wait_state(3'd2, 20, "play_b");
    repeat (3) cycle();
    aliens_defeated = 1'b1;
    reached_bottom = 1'b1;
    wait_state(3'd5, 10, "lost");
    aliens_defeated = 1'b0;
    reached_bottom = 1'b0;
    chk("lost_lose", lose, 1);
    chk("lost_win", win, 0);
    chk("lost_level", level, 0);
    start = 1'b0;
    wait_state(3'd0, 10, "lost_to_idle");

    // Score saturation, then hits ignored outside PLAY
    start = 1'b1;
    wait_state(3'd2, 20, "play_c");
    hits(300);
    chk("score_sat", score, 255);
    reached_bottom = 1'b1;
    wait_state(3'd5, 10, "lost_c");
    reached_bottom = 1'b0;
    hits(3);
    chk("score_lost_hold", score, 255);
    chk("lost_c_stay", state, 5);

    // Start held through reset release must not start a game
    reset = 1'b1;
    cycle(); cycle();
    reset = 1'b0;
    repeat (10) cycle();
    chk("held_start_idle", state, 0);
    start = 1'b0;
    repeat (4) cycle();
    start = 1'b1;
    wait_state(3'd1, 6, "restart_init");
    wait_state(3'd2, 10, "play_d");
    start = 1'b0;
    wait_state(3'd0, 6, "abort_idle");
    chk("abort_game_rst", game_rst, 1);

    // Reset mid-PLAY with a non-zero score
    start = 1'b1;
    wait_state(3'd2, 20, "play_e");
    hits(7);
    chk("score7", score, 7);
    reset = 1'b1;
    cycle();
    chk("midrst_state", state, 0);
    chk("midrst_score", score, 0);
    chk("midrst_level", level, 0);
    chk("midrst_tick", tick_en, 0);
    chk("midrst_game_rst", game_rst, 1);
    reset = 1'b0;
    start = 1'b0;
    repeat (4) cycle();

    // Randomized phase
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(59, 0) == 0) start = ~start;
      if ($urandom_range(24, 0) == 0) aliens_defeated = ~aliens_defeated;
      if ($urandom_range(79, 0) == 0) reached_bottom = ~reached_bottom;
      if ($urandom_range(2, 0) == 0) collision = ~collision;
      reset = ($urandom_range(399, 0) == 0);
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
